cache_memory: RTL and testbench

// - Direct-mapped, write-through, write-allocate cache between a CPU port and a line-wide RAM port.
// - Sits between the CPU and the memory interface (MI).
// - Hits serve CPU reads with no RAM traffic; misses fill the whole line in one RAM transaction.
// - Every CPU write is forwarded to RAM as a full updated line.

---
 rtl/cache_memory.sv | 199 +++++++++++++++++++
 tb/tb_cache_memory.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_memory.sv
// Direct-mapped, write-through, write-allocate cache between a CPU word port and a line-wide RAM port.
// Optional macro CACHE_FAST_HIT_EN: read hits complete straight from IDLE using the live address.
module cache_memory (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [13:0]  CPU_ADDR,
  input  logic         SIG_CPU_RD,
  input  logic         SIG_CPU_WR,
  input  logic [31:0]  CPU_OUT_DATA,
  input  logic [3:0]   CPU_B_VAL,
  input  logic [127:0] MI_OUT_DATA,
  input  logic         MI_SIG_RAM_ACK,
  output logic         ACK,
  output logic         SIG_RAM_RD,
  output logic         SIG_RAM_WR,
  output logic [137:0] MI_IN_DATA,
  output logic [31:0]  CPU_IN_DATA
);

  localparam int unsigned c_ADDR_OFFSET_SIZE = 4;
  localparam int unsigned c_ADDR_INDEX_SIZE  = 4;
  localparam int unsigned c_ADDR_TAG_SIZE    = 6;
  localparam int unsigned c_CPU_DATA_SIZE    = 32;
  localparam int unsigned c_B_VAL_SIZE       = 4;
  localparam int unsigned c_RAM_DATA_SIZE    = 128;
  localparam int unsigned LA_W    = c_ADDR_TAG_SIZE + c_ADDR_INDEX_SIZE;
  localparam int unsigned ADDR_W  = LA_W + c_ADDR_OFFSET_SIZE;
  localparam int unsigned ALIGN_W = ADDR_W - 2;
  localparam int unsigned MI_W    = c_RAM_DATA_SIZE + LA_W;
  localparam int unsigned LINES   = 1 << c_ADDR_INDEX_SIZE;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL, S_WRITE} state_t;

  state_t                       state_q, state_d;
  logic [ALIGN_W-1:0]           addr_q, addr_d;
  logic [c_CPU_DATA_SIZE-1:0]   wdata_q, wdata_d;
  logic [c_B_VAL_SIZE-1:0]      be_q, be_d;
  logic                         is_rd_q, is_rd_d;
  logic                         ack_q, ack_d;
  logic                         ram_rd_q, ram_rd_d;
  logic                         ram_wr_q, ram_wr_d;
  logic [MI_W-1:0]              mi_in_q, mi_in_d;
  logic [c_CPU_DATA_SIZE-1:0]   cpu_rd_q, cpu_rd_d;

  logic [LINES-1:0]             valid_q;
  logic [c_ADDR_TAG_SIZE-1:0]   tag_q  [LINES];
  logic [c_RAM_DATA_SIZE-1:0]   line_q [LINES];

  logic                         line_we_c;
  logic                         valid_set_c;
  logic [c_RAM_DATA_SIZE-1:0]   line_wdata_c;

  logic [c_ADDR_INDEX_SIZE-1:0] idx_c;
  logic [c_ADDR_TAG_SIZE-1:0]   tag_c;
  logic [1:0]                   word_c;
  logic [c_RAM_DATA_SIZE-1:0]   cur_line_c;
  logic [c_RAM_DATA_SIZE-1:0]   merged_c;
  logic                         hit_c;
  logic                         unused_addr_c;

  assign unused_addr_c = ^CPU_ADDR[1:0];

  assign tag_c      = addr_q[ALIGN_W-1 -: c_ADDR_TAG_SIZE];
  assign idx_c      = addr_q[c_ADDR_INDEX_SIZE+1:2];
  assign word_c     = addr_q[1:0];
  assign cur_line_c = line_q[idx_c];
  assign hit_c      = valid_q[idx_c] && (tag_q[idx_c] == tag_c);

  // Byte-enable merge of the latched write word into the indexed line
  always_comb begin
    merged_c = cur_line_c;
    for (int b = 0; b < int'(c_B_VAL_SIZE); b++) begin
      if (be_q[b]) merged_c[{word_c, 2'(b), 3'd0} +: 8] = wdata_q[8*b +: 8];
    end
  end

`ifdef CACHE_FAST_HIT_EN
  logic [c_ADDR_INDEX_SIZE-1:0] live_idx_c;
  logic                         live_hit_c;
  logic [c_CPU_DATA_SIZE-1:0]   live_word_c;
  assign live_idx_c  = CPU_ADDR[c_ADDR_OFFSET_SIZE +: c_ADDR_INDEX_SIZE];
  assign live_hit_c  = valid_q[live_idx_c] &&
                       (tag_q[live_idx_c] == CPU_ADDR[ADDR_W-1 -: c_ADDR_TAG_SIZE]);
  assign live_word_c = line_q[live_idx_c][{CPU_ADDR[3:2], 5'd0} +: 32];
`endif

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    is_rd_d      = is_rd_q;
    ack_d        = 1'b0;
    ram_rd_d     = ram_rd_q;
    ram_wr_d     = ram_wr_q;
    mi_in_d      = mi_in_q;
    cpu_rd_d     = cpu_rd_q;
    line_we_c    = 1'b0;
    valid_set_c  = 1'b0;
    line_wdata_c = merged_c;
    unique case (state_q)
      S_IDLE: begin
        if (SIG_CPU_RD || SIG_CPU_WR) begin
          addr_d  = CPU_ADDR[ADDR_W-1:2];
          wdata_d = CPU_OUT_DATA;
          be_d    = CPU_B_VAL;
          is_rd_d = SIG_CPU_RD;
`ifdef CACHE_FAST_HIT_EN
          if (SIG_CPU_RD && live_hit_c) begin
            cpu_rd_d = live_word_c;
            ack_d    = 1'b1;
          end else begin
            state_d = S_LOOKUP;
          end
`else
          state_d = S_LOOKUP;
`endif
        end
      end
      S_LOOKUP: begin
        if (hit_c && is_rd_q) begin
          cpu_rd_d = cur_line_c[{word_c, 5'd0} +: 32];
          ack_d    = 1'b1;
          state_d  = S_IDLE;
        end else if (hit_c) begin
          line_we_c = 1'b1;
          mi_in_d   = {merged_c, tag_c, idx_c};
          ram_wr_d  = 1'b1;
          state_d   = S_WRITE;
        end else begin
          mi_in_d  = {{c_RAM_DATA_SIZE{1'b0}}, tag_c, idx_c};
          ram_rd_d = 1'b1;
          state_d  = S_FILL;
        end
      end
      S_FILL: begin
        if (MI_SIG_RAM_ACK) begin
          line_we_c    = 1'b1;
          valid_set_c  = 1'b1;
          line_wdata_c = MI_OUT_DATA;
          ram_rd_d     = 1'b0;
          state_d      = S_LOOKUP;
        end
      end
      S_WRITE: begin
        if (MI_SIG_RAM_ACK) begin
          ram_wr_d = 1'b0;
          ack_d    = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      is_rd_q  <= 1'b0;
      ack_q    <= 1'b0;
      ram_rd_q <= 1'b0;
      ram_wr_q <= 1'b0;
      mi_in_q  <= '0;
      cpu_rd_q <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      is_rd_q  <= is_rd_d;
      ack_q    <= ack_d;
      ram_rd_q <= ram_rd_d;
      ram_wr_q <= ram_wr_d;
      mi_in_q  <= mi_in_d;
      cpu_rd_q <= cpu_rd_d;
      if (valid_set_c) valid_q[idx_c] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset; valid bits gate every use
  always_ff @(posedge CLK) begin
    if (line_we_c) begin
      line_q[idx_c] <= line_wdata_c;
      tag_q[idx_c]  <= tag_c;
    end
  end

  assign ACK         = ack_q;
  assign SIG_RAM_RD  = ram_rd_q;
  assign SIG_RAM_WR  = ram_wr_q;
  assign MI_IN_DATA  = mi_in_q;
  assign CPU_IN_DATA = cpu_rd_q;

endmodule

// File: tb/tb_cache_memory.sv
// Self-checking bench for cache_memory: directed table, reset/overlap corner cases, random ops vs. a line-memory model.
module tb_cache_memory;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [13:0]  CPU_ADDR;
  logic         SIG_CPU_RD;
  logic         SIG_CPU_WR;
  logic [31:0]  CPU_OUT_DATA;
  logic [3:0]   CPU_B_VAL;
  logic [127:0] MI_OUT_DATA;
  logic         MI_SIG_RAM_ACK;
  logic         ACK;
  logic         SIG_RAM_RD;
  logic         SIG_RAM_WR;
  logic [137:0] MI_IN_DATA;
  logic [31:0]  CPU_IN_DATA;

`ifdef CACHE_FAST_HIT_EN
  localparam int HIT_LAT = 0;
`else
  localparam int HIT_LAT = 1;
`endif

  cache_memory dut (
    .CLK(CLK), .RESET(RESET), .CPU_ADDR(CPU_ADDR), .SIG_CPU_RD(SIG_CPU_RD),
    .SIG_CPU_WR(SIG_CPU_WR), .CPU_OUT_DATA(CPU_OUT_DATA), .CPU_B_VAL(CPU_B_VAL),
    .MI_OUT_DATA(MI_OUT_DATA), .MI_SIG_RAM_ACK(MI_SIG_RAM_ACK), .ACK(ACK),
    .SIG_RAM_RD(SIG_RAM_RD), .SIG_RAM_WR(SIG_RAM_WR), .MI_IN_DATA(MI_IN_DATA),
    .CPU_IN_DATA(CPU_IN_DATA)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference: backing memory of lines plus which line each cache slot holds
  logic [127:0] ram [1024];
  bit           m_valid [16];
  logic [5:0]   m_tag [16];
  logic [31:0]  last_rd;

  typedef struct {
    bit          rd;
    logic [13:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    int          miss;
    logic [31:0] rdata;
    logic [127:0] line;
  } vec_t;

  task automatic chk(input string nm, input logic [137:0] got, input logic [137:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [127:0] merge(input logic [127:0] l, input logic [13:0] a,
                                          input logic [31:0] d, input logic [3:0] be);
    logic [7:0] bytes [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) bytes[i] = l[8*i +: 8];
    for (int b = 0; b < 4; b++)
      if (be[b]) bytes[int'(a[3:2]) * 4 + b] = d[8*b +: 8];
    for (int i = 0; i < 16; i++) r[8*i +: 8] = bytes[i];
    return r;
  endfunction

  // Predicts the outcome of one request and records the slot allocation
  task automatic model_step(input bit rd, input logic [13:0] a, input logic [31:0] wd,
                            input logic [3:0] be, output int miss, output logic [31:0] rdata,
                            output logic [127:0] line);
    int idx;
    logic [127:0] cur;
    idx  = int'(a[7:4]);
    miss = (m_valid[idx] && m_tag[idx] == a[13:8]) ? 0 : 1;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = a[13:8];
    cur  = ram[a[13:4]];
    line = rd ? 128'h0 : merge(cur, a, wd, be);
    if (rd) last_rd = cur[32*int'(a[3:2]) +: 32];
    rdata = last_rd;
  endtask

  // Issues one request, acts as RAM, and reports what the DUT did
  task automatic do_op(input bit rd, input logic [13:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int lat, input bit poke,
                       output int o_miss, output int o_wr, output int o_ack_cyc,
                       output int o_rd_cyc, output logic [127:0] o_line);
    int cnt = -1;
    int post = -1;
    int acks = 0;
    bit prd = 1'b0, pwr = 1'b0, poke_pend = 1'b0;
    o_miss = 0; o_wr = 0; o_ack_cyc = -1; o_rd_cyc = -1; o_line = '0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge CLK);
      if (cyc == 0) begin
        SIG_CPU_RD = rd; SIG_CPU_WR = !rd; CPU_ADDR = a; CPU_OUT_DATA = wd; CPU_B_VAL = be;
      end else begin
        SIG_CPU_RD = 1'b0; SIG_CPU_WR = 1'b0;
        if (poke_pend) begin
          SIG_CPU_RD = 1'b1; CPU_ADDR = a ^ 14'h0100; poke_pend = 1'b0;
        end
      end
      MI_SIG_RAM_ACK = 1'b0;
      if (cnt == 0) begin
        MI_SIG_RAM_ACK = 1'b1;
        MI_OUT_DATA    = ram[a[13:4]];
      end
      if (cnt >= 0) cnt--;
      @(posedge CLK); #1;
      if (SIG_RAM_RD && !prd) begin
        o_miss++;
        if (o_rd_cyc < 0) o_rd_cyc = cyc;
        chk("rd_req_field", MI_IN_DATA, {128'h0, a[13:4]});
        cnt = lat;
        poke_pend = poke;
      end
      if (SIG_RAM_WR && !pwr) begin
        o_wr++;
        o_line = MI_IN_DATA[137:10];
        chk("wr_req_addr", 138'(MI_IN_DATA[9:0]), 138'(a[13:4]));
        cnt = lat;
      end
      prd = SIG_RAM_RD;
      pwr = SIG_RAM_WR;
      if (ACK) begin
        acks++;
        if (o_ack_cyc < 0) o_ack_cyc = cyc;
        post = 0;
      end
      if (post >= 0) begin
        if (post == 4) break;
        post++;
      end
    end
    chk("ack_count", 138'(acks), 138'(1));
    chk("idle_after_op", 138'({SIG_RAM_RD, SIG_RAM_WR}), 138'(0));
  endtask

  task automatic run_checked(input string nm, input bit rd, input logic [13:0] a,
                             input logic [31:0] wd, input logic [3:0] be, input int lat,
                             input bit poke, input int exp_miss, input logic [31:0] exp_rd,
                             input logic [127:0] exp_line);
    int miss, wr, ack_cyc, rd_cyc;
    logic [127:0] line;
    do_op(rd, a, wd, be, lat, poke, miss, wr, ack_cyc, rd_cyc, line);
    chk({nm, "_miss"}, 138'(miss), 138'(exp_miss));
    chk({nm, "_wr"}, 138'(wr), 138'(!rd));
    chk({nm, "_rdata"}, 138'(CPU_IN_DATA), 138'(exp_rd));
    if (!rd) begin
      chk({nm, "_line"}, 138'(line), 138'(exp_line));
      ram[a[13:4]] = exp_line;
    end
    if (rd && exp_miss == 0) chk({nm, "_hit_lat"}, 138'(ack_cyc), 138'(HIT_LAT));
    if (exp_miss != 0) chk({nm, "_miss_lat"}, 138'(rd_cyc), 138'(1));
  endtask

  initial begin
    vec_t tbl [6];
    int   m, acks;
    logic [31:0] r;
    logic [127:0] l;

    RESET = 1'b0; CPU_ADDR = '0; SIG_CPU_RD = 1'b0; SIG_CPU_WR = 1'b0;
    CPU_OUT_DATA = '0; CPU_B_VAL = '0; MI_OUT_DATA = '0; MI_SIG_RAM_ACK = 1'b0;
    for (int i = 0; i < 1024; i++) ram[i] = {$urandom, $urandom, $urandom, $urandom};
    ram[10'h021] = 128'h88888888;
    ram[10'h3F1] = 128'h0;
    for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_tag[i] = '0; end
    last_rd = '0;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ack", 138'(ACK), 138'(0));
    chk("rst_ram_rd", 138'(SIG_RAM_RD), 138'(0));
    chk("rst_ram_wr", 138'(SIG_RAM_WR), 138'(0));
    chk("rst_mi_in", MI_IN_DATA, 138'(0));
    chk("rst_cpu_in", 138'(CPU_IN_DATA), 138'(0));
    @(negedge CLK) RESET = 1'b1;

    tbl[0] = '{1'b1, 14'h0210, 32'h0,        4'h0, 1, 32'h88888888, 128'h0};
    tbl[1] = '{1'b1, 14'h0210, 32'h0,        4'h0, 0, 32'h88888888, 128'h0};
    tbl[2] = '{1'b0, 14'h021C, 32'h11111111, 4'hF, 0, 32'h88888888,
               {32'h11111111, 64'h0, 32'h88888888}};
    tbl[3] = '{1'b0, 14'h3F1C, 32'h11111111, 4'h3, 1, 32'h88888888, {32'h00001111, 96'h0}};
    tbl[4] = '{1'b1, 14'h0210, 32'h0,        4'h0, 1, 32'h88888888, 128'h0};
    tbl[5] = '{1'b1, 14'h021C, 32'h0,        4'h0, 0, 32'h11111111, 128'h0};
    for (int i = 0; i < 6; i++) begin
      model_step(tbl[i].rd, tbl[i].a, tbl[i].wd, tbl[i].be, m, r, l);
      run_checked($sformatf("vec%0d", i), tbl[i].rd, tbl[i].a, tbl[i].wd, tbl[i].be, 1, 1'b0,
                  tbl[i].miss, tbl[i].rdata, tbl[i].line);
    end

    // Reset while a line fill is outstanding
    @(negedge CLK); SIG_CPU_RD = 1'b1; CPU_ADDR = 14'h0510;
    @(negedge CLK); SIG_CPU_RD = 1'b0;
    for (int i = 0; i < 10 && !SIG_RAM_RD; i++) begin @(posedge CLK); #1; end
    chk("fill_started", 138'(SIG_RAM_RD), 138'(1));
    @(negedge CLK) RESET = 1'b0;
    @(posedge CLK); #1;
    chk("rstfill_ram_rd", 138'(SIG_RAM_RD), 138'(0));
    chk("rstfill_ack", 138'(ACK), 138'(0));
    chk("rstfill_mi_in", MI_IN_DATA, 138'(0));
    chk("rstfill_cpu_in", 138'(CPU_IN_DATA), 138'(0));
    @(negedge CLK) RESET = 1'b1;
    acks = 0;
    repeat (4) begin @(posedge CLK); #1; if (ACK) acks++; end
    chk("rstfill_no_ack", 138'(acks), 138'(0));
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    last_rd = '0;

    // Stray RAM ack while idle
    @(negedge CLK) MI_SIG_RAM_ACK = 1'b1;
    @(posedge CLK); #1;
    chk("stray_ack", 138'({ACK, SIG_RAM_RD, SIG_RAM_WR}), 138'(0));
    @(negedge CLK) MI_SIG_RAM_ACK = 1'b0;

    model_step(1'b1, 14'h0210, 32'h0, 4'h0, m, r, l);
    run_checked("reread_after_rst", 1'b1, 14'h0210, 32'h0, 4'h0, 1, 1'b0, 1, r, l);

    model_step(1'b1, 14'h0450, 32'h0, 4'h0, m, r, l);
    run_checked("overlap_rd", 1'b1, 14'h0450, 32'h0, 4'h0, 3, 1'b1, m, r, l);

    for (int n = 0; n < 40; n++) begin
      bit          rd;
      logic [13:0] a;
      logic [31:0] wd;
      logic [3:0]  be;
      rd = 1'($urandom);
      a  = {6'($urandom_range(0, 3)), 4'($urandom), 4'($urandom)};
      wd = $urandom;
      be = 4'($urandom);
      model_step(rd, a, wd, be, m, r, l);
      run_checked($sformatf("rnd%0d", n), rd, a, wd, be, int'($urandom_range(0, 3)), 1'b0, m, r, l);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
